// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard
//  Description : Register write scoreboard. Tracks up to three in-flight writes
//                per architectural register (x1..x31), stalls issue on RAW or
//                counter saturation, and flags write-backs that match nothing.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic        issue_regwrite,
    input  logic [4:0]  issue_rd,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        flush,
    output logic        stall,
    output logic        issue_accept,
    output logic [31:0] pending,
    output logic [6:0]  inflight_count,
    output logic        wb_error
);

    localparam logic [1:0] C_CNT_MAX = 2'd3;

    // Per-register in-flight counters; x0 is never tracked.
    logic [1:0]        r_cnt [1:31];
    logic [31:0][1:0]  w_cntAll;
    logic [6:0]        r_inflight;
    logic              r_wbError;

    logic w_rdFull;
    logic w_inc;
    logic w_wbLive;
    logic w_dec;
    logic w_wbErr;

    // Flatten counters into a 32-entry view with x0 hard-wired to zero so any
    // 5-bit index can be used directly.
    always_comb begin
        w_cntAll = '0;
        for (int i = 1; i < 32; i++) begin
            w_cntAll[i] = r_cnt[i];
        end
    end

    // Pending bit per register: at least one write outstanding.
    always_comb begin
        pending = '0;
        for (int i = 1; i < 32; i++) begin
            pending[i] = (r_cnt[i] != 2'd0);
        end
    end

    // Issue hazard detection and acceptance; write-backs do not bypass here.
    always_comb begin
        w_rdFull     = issue_regwrite && (issue_rd != 5'd0) && (w_cntAll[issue_rd] == C_CNT_MAX);
        stall        = issue_valid && (pending[issue_rs1] || pending[issue_rs2] || w_rdFull);
        issue_accept = issue_valid && !stall && !flush;
        w_inc        = issue_accept && issue_regwrite && (issue_rd != 5'd0);
        w_wbLive     = wb_valid && (wb_rd != 5'd0);
        w_dec        = w_wbLive && (w_cntAll[wb_rd] != 2'd0);
        w_wbErr      = w_wbLive && (w_cntAll[wb_rd] == 2'd0) && !flush;
    end

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_cnt
            logic w_incHit;
            logic w_decHit;
            assign w_incHit = w_inc && (issue_rd == 5'(gi));
            assign w_decHit = w_dec && (wb_rd == 5'(gi));

            // Counter update: flush clears; matching issue and write-back cancel.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cnt[gi] <= 2'd0;
                end else if (flush) begin
                    r_cnt[gi] <= 2'd0;
                end else if (w_incHit && !w_decHit) begin
                    r_cnt[gi] <= r_cnt[gi] + 2'd1;
                end else if (w_decHit && !w_incHit) begin
                    r_cnt[gi] <= r_cnt[gi] - 2'd1;
                end
            end
        end
    endgenerate

    // Total in-flight writes tracks the counters edge for edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inflight <= 7'd0;
        end else if (flush) begin
            r_inflight <= 7'd0;
        end else begin
            r_inflight <= r_inflight + {6'd0, w_inc} - {6'd0, w_dec};
        end
    end

    // Sticky error for a write-back to a register with nothing outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wbError <= 1'b0;
        end else if (w_wbErr) begin
            r_wbError <= 1'b1;
        end
    end

    assign inflight_count = r_inflight;
    assign wb_error       = r_wbError;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_scoreboard
//  Description : Self-checking bench for reg_scoreboard with a count-array
//                reference model, directed scenarios and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_regwrite;
    logic [4:0]  issue_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        stall;
    logic        issue_accept;
    logic [31:0] pending;
    logic [6:0]  inflight_count;
    logic        wb_error;

    int errors = 0;
    int checks = 0;

    // Reference model: outstanding writes per register and sticky error.
    int mCnt [32];
    bit mErr;
    bit lastStall;
    bit lastAccept;

    reg_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_rs1      (issue_rs1),
        .issue_rs2      (issue_rs2),
        .issue_regwrite (issue_regwrite),
        .issue_rd       (issue_rd),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .flush          (flush),
        .stall          (stall),
        .issue_accept   (issue_accept),
        .pending        (pending),
        .inflight_count (inflight_count),
        .wb_error       (wb_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] modelPending();
        logic [31:0] p;
        p = '0;
        for (int i = 1; i < 32; i++) p[i] = (mCnt[i] != 0);
        return p;
    endfunction

    function automatic int modelSum();
        int s;
        s = 0;
        for (int i = 1; i < 32; i++) s += mCnt[i];
        return s;
    endfunction

    task automatic modelClear();
        for (int i = 0; i < 32; i++) mCnt[i] = 0;
        mErr = 1'b0;
    endtask

    task automatic checkState(input string tag);
        chk({tag, ".pending"},  pending,               modelPending());
        chk({tag, ".inflight"}, 32'(inflight_count),   32'(modelSum()));
        chk({tag, ".wb_error"}, 32'(wb_error),         32'(mErr));
    endtask

    // One clock cycle: drive at posedge+1, check combinational outputs, then
    // advance the model on the edge and check the registered state.
    task automatic step(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input bit rw, input logic [4:0] rd,
                        input bit wv, input logic [4:0] wrd, input bit fl);
        bit  expStall;
        bit  expAcc;
        bit  wbHit;
        issue_valid    = v;
        issue_rs1      = rs1;
        issue_rs2      = rs2;
        issue_regwrite = rw;
        issue_rd       = rd;
        wb_valid       = wv;
        wb_rd          = wrd;
        flush          = fl;
        #1;
        expStall = v && (mCnt[rs1] > 0 || mCnt[rs2] > 0 || (rw && rd != 0 && mCnt[rd] == 3));
        expAcc   = v && !expStall && !fl;
        chk("stall",  32'(stall),        32'(expStall));
        chk("accept", 32'(issue_accept), 32'(expAcc));
        lastStall  = stall;
        lastAccept = issue_accept;
        @(posedge clk);
        if (fl) begin
            for (int i = 0; i < 32; i++) mCnt[i] = 0;
        end else begin
            wbHit = wv && wrd != 0 && mCnt[wrd] > 0;
            if (wv && wrd != 0 && mCnt[wrd] == 0) mErr = 1'b1;
            if (wbHit) mCnt[wrd] = mCnt[wrd] - 1;
            if (expAcc && rw && rd != 0) mCnt[rd] = mCnt[rd] + 1;
        end
        #1;
        checkState("post");
    endtask

    task automatic idleInputs();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_regwrite = 0;
        issue_rd = 0; wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    // Asynchronous reset applied mid-cycle, checked before any clock edge.
    task automatic applyReset();
        idleInputs();
        rst = 1'b0;
        #1;
        modelClear();
        checkState("rst_async");
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [4:0] rdR;
        logic [4:0] wrdR;
        idleInputs();
        modelClear();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkState("reset");
        chk("reset.stall", 32'(stall), 32'd0);
        issue_valid = 1; issue_rs1 = 5; issue_regwrite = 1; issue_rd = 5;
        #1;
        chk("reset.accept", 32'(issue_accept), 32'd1);
        idleInputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkState("release");

        // Load-use hazard resolved by write-back, no same-cycle bypass.
        step(1, 0, 0, 1, 5, 0, 0, 0);
        step(1, 5, 0, 0, 0, 0, 0, 0);
        chk("lu.stall", 32'(lastStall), 32'd1);
        chk("lu.pend5", 32'(pending[5]), 32'd1);
        step(1, 5, 0, 0, 0, 1, 5, 0);
        chk("lu.nobypass", 32'(lastStall), 32'd1);
        chk("lu.inflight0", 32'(inflight_count), 32'd0);
        step(1, 5, 0, 0, 0, 0, 0, 0);
        chk("lu.clear", 32'(lastStall), 32'd0);

        // Saturation at three outstanding writes.
        step(1, 0, 0, 1, 7, 0, 0, 0);
        step(1, 0, 0, 1, 7, 0, 0, 0);
        step(1, 0, 0, 1, 7, 0, 0, 0);
        chk("sat.inflight3", 32'(inflight_count), 32'd3);
        step(1, 0, 0, 1, 7, 0, 0, 0);
        chk("sat.stall", 32'(lastStall), 32'd1);
        step(1, 0, 0, 1, 7, 1, 7, 0);
        chk("sat.stall_wb", 32'(lastStall), 32'd1);
        step(1, 0, 0, 1, 7, 0, 0, 0);
        chk("sat.accept", 32'(lastAccept), 32'd1);
        chk("sat.inflight", 32'(inflight_count), 32'd3);
        step(0, 0, 0, 0, 0, 0, 0, 1);

        // Simultaneous issue and write-back to the same register.
        step(1, 0, 0, 1, 9, 0, 0, 0);
        step(1, 0, 0, 1, 9, 1, 9, 0);
        chk("sim.pend9", 32'(pending[9]), 32'd1);
        chk("sim.inflight", 32'(inflight_count), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 1);

        // x0 is never tracked.
        step(1, 0, 0, 1, 0, 1, 0, 0);
        chk("x0.pending", pending, 32'd0);
        chk("x0.err", 32'(wb_error), 32'd0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("x0.nostall", 32'(lastStall), 32'd0);

        // Flush discards same-cycle issue and write-back.
        step(1, 0, 0, 1, 3, 0, 0, 0);
        step(1, 0, 0, 1, 4, 0, 0, 0);
        step(1, 0, 0, 1, 5, 0, 0, 0);
        step(1, 0, 0, 1, 6, 1, 3, 1);
        chk("fl.pending", pending, 32'd0);
        chk("fl.inflight", 32'(inflight_count), 32'd0);
        chk("fl.err", 32'(wb_error), 32'd0);
        step(0, 0, 0, 0, 0, 1, 3, 1);
        chk("fl.err_wb0", 32'(wb_error), 32'd0);

        // Randomized traffic over a small register window to force collisions.
        for (int r = 0; r < 4; r++) begin
            for (int n = 0; n < 80; n++) begin
                rdR  = 5'($urandom_range(0, 8));
                wrdR = 5'($urandom_range(0, 8));
                if (($urandom % 4) != 0 && modelSum() > 0) begin
                    for (int k = 0; k < 8; k++) begin
                        if (mCnt[wrdR] == 0) wrdR = 5'((wrdR % 8) + 1);
                    end
                end
                step(1'($urandom % 4 != 0),
                     5'($urandom_range(0, 10)), 5'($urandom_range(0, 10)),
                     1'($urandom % 5 != 0), rdR,
                     1'($urandom % 2), wrdR,
                     1'($urandom % 25 == 0));
            end
            applyReset();
            step(0, 0, 0, 0, 0, 0, 0, 0);
        end

        // Sticky error and asynchronous reset.
        step(0, 0, 0, 0, 0, 1, 12, 0);
        chk("err.set", 32'(wb_error), 32'd1);
        step(1, 0, 0, 1, 12, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 12, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("err.sticky", 32'(wb_error), 32'd1);
        step(1, 0, 0, 1, 12, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst.err", 32'(wb_error), 32'd0);
        chk("arst.pending", pending, 32'd0);
        chk("arst.inflight", 32'(inflight_count), 32'd0);
        modelClear();
        idleInputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1, 12, 0, 1, 12, 0, 0, 0);
        chk("arst.first", 32'(lastAccept), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
